// File: rtl/mux_sel_arb.sv
// Round-robin arbiter driving the select lines of a downstream 4:1 mux, with a dwell limit per grant.
// Optional grant-extend via lock is built only when MUX_SEL_LOCK_EN is defined.
module mux_sel_arb #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       s1,
    output logic       s0,
    output logic [3:0] gnt,
    output logic       valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;

    logic       at_last_s;
    logic       hold_s;
    logic       expire_s;
    logic       release_s;
    logic [1:0] win_idle_s;
    logic [1:0] win_rel_s;

    // Winner search starts after the last granted channel and wraps back to it.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    assign at_last_s = (cnt_q == DWELL_LAST);

`ifdef MUX_SEL_LOCK_EN
    assign hold_s = lock;
`else
    logic unused_lock_s;
    assign unused_lock_s = lock;
    assign hold_s        = 1'b0;
`endif

    assign expire_s   = at_last_s & ~hold_s;
    assign release_s  = expire_s | ~req[sel_q];
    assign win_idle_s = rr_pick(req, ptr_q);
    assign win_rel_s  = rr_pick(req, sel_q);

    // Next-state and next-output computation for both arbiter states.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(win_idle_s);
                    sel_d   = win_idle_s;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    valid_d = 1'b0;
                    gnt_d   = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    ptr_d = sel_q;
                    cnt_d = 8'd0;
                    if (req != 4'b0000) begin
                        gnt_d   = onehot(win_rel_s);
                        sel_d   = win_rel_s;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else if (at_last_s) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign gnt   = gnt_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_sel_arb.sv
// Directed self-checking bench for mux_sel_arb: a DWELL=4 instance plus a DWELL=1 instance on shared stimulus.
module tb_mux_sel_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic       s1, s0, valid;
    logic [3:0] gnt;
    logic       s1_b, s0_b, valid_b;
    logic [3:0] gnt_b;

    int checks;
    int failures;

    mux_sel_arb #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .s1(s1), .s0(s0), .gnt(gnt), .valid(valid)
    );

    mux_sel_arb #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .s1(s1_b), .s0(s0_b), .gnt(gnt_b), .valid(valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        lock = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid !== 1'b0 || gnt !== 4'b0000 || {s1, s0} !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got valid=%b gnt=%b sel=%b%b want 0 0000 00", i, valid, gnt, s1, s0);
            end
            step();
        end
    endtask

    task automatic test_rotate();
        logic [3:0] eg;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 20; n++) begin
            step();
            eg = 4'b0001 << ((n / 4) % 4);
            checks++;
            if (gnt !== eg || {s1, s0} !== 2'((n / 4) % 4) || valid !== 1'b1) begin
                failures++;
                $display("FAIL rotate n=%0d got gnt=%b sel=%b%b valid=%b want gnt=%b valid=1", n, gnt, s1, s0, valid, eg);
            end
            eg = 4'b0001 << (n % 4);
            checks++;
            if (gnt_b !== eg || {s1_b, s0_b} !== 2'(n % 4) || valid_b !== 1'b1) begin
                failures++;
                $display("FAIL rotate_dwell1 n=%0d got gnt=%b valid=%b want gnt=%b valid=1", n, gnt_b, valid_b, eg);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0100;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL pre_grant got valid=%b want 0", valid);
        end
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (valid !== 1'b1 || gnt !== 4'b0100 || {s1, s0} !== 2'b10) begin
                failures++;
                $display("FAIL early_grant n=%0d got valid=%b gnt=%b sel=%b%b want 1 0100 10", n, valid, gnt, s1, s0);
            end
        end
        req = 4'b0000;
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (valid !== 1'b0 || gnt !== 4'b0000 || {s1, s0} !== 2'b10) begin
                failures++;
                $display("FAIL early_idle n=%0d got valid=%b gnt=%b sel=%b%b want 0 0000 10", n, valid, gnt, s1, s0);
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        req = 4'b0010;
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if (gnt !== 4'b0010 || valid !== 1'b1 || dut.cnt_q !== 8'(n % 4)) begin
                failures++;
                $display("FAIL sole n=%0d got gnt=%b valid=%b cnt=%0d want 0010 1 %0d", n, gnt, valid, dut.cnt_q, n % 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000;
        for (int n = 0; n < 3; n++) step();
        checks++;
        if (gnt !== 4'b1000 || dut.cnt_q !== 8'd2) begin
            failures++;
            $display("FAIL mid_setup got gnt=%b cnt=%0d want 1000 2", gnt, dut.cnt_q);
        end
        req = 4'b1001;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || gnt !== 4'b0000 || {s1, s0} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset got valid=%b gnt=%b sel=%b%b want 0 0000 00", valid, gnt, s1, s0);
        end
        step();
        checks++;
        if (valid !== 1'b1 || gnt !== 4'b0001 || {s1, s0} !== 2'b00) begin
            failures++;
            $display("FAIL mid_regrant got valid=%b gnt=%b sel=%b%b want 1 0001 00", valid, gnt, s1, s0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0101;
        step();
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || valid !== 1'b1 || {s1, s0} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_drop got gnt=%b valid=%b sel=%b%b want 0100 1 10", gnt, valid, s1, s0);
        end
        // New requesters appear mid-grant; channel 2 keeps the grant until expiry.
        req = 4'b0111;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (gnt !== 4'b0100) begin
                failures++;
                $display("FAIL no_preempt n=%0d got gnt=%b want 0100", n, gnt);
            end
        end
        step();
        checks++;
        if (gnt !== 4'b0001 || valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_expire got gnt=%b valid=%b want 0001 1", gnt, valid);
        end
        for (int n = 0; n < 3; n++) step();
        req = 4'b0110;
        step();
        checks++;
        if (gnt !== 4'b0010 || valid !== 1'b1 || {s1, s0} !== 2'b01) begin
            failures++;
            $display("FAIL expire_and_drop got gnt=%b valid=%b sel=%b%b want 0010 1 01", gnt, valid, s1, s0);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req  = 4'b0011;
        lock = 1'b1;
`ifdef MUX_SEL_LOCK_EN
        for (int n = 0; n < 8; n++) begin
            step();
            checks++;
            if (gnt !== 4'b0001) begin
                failures++;
                $display("FAIL lock_hold n=%0d got gnt=%b want 0001", n, gnt);
            end
        end
        lock = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL lock_release got gnt=%b want 0010", gnt);
        end
`else
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (gnt !== ((n < 4) ? 4'b0001 : 4'b0010)) begin
                failures++;
                $display("FAIL lock_ignored n=%0d got gnt=%b want %b", n, gnt, (n < 4) ? 4'b0001 : 4'b0010);
            end
        end
        lock = 1'b0;
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        lock     = 1'b0;
        test_reset();
        test_rotate();
        test_early_release();
        test_sole();
        test_reset_mid();
        test_back_to_back();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
